mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access unit sitting directly behind the execute/memory pipeline register. It consumes that register's load/store/ALU-result outputs and runs each load or store as a request/acknowledge transaction on the data bus toward memory or I/O. It stalls the upstream pipeline while a transaction is outstanding and drives the registered writeback port toward the register file. A wait-state timeout prevents a missing acknowledge from hanging the core.

## Interface
- TIMEOUT, 15: maximum number of bus cycles with busReq high before the access is abandoned (range 1-255).
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- isLoad  in  1  current op is a load.
- isStore  in  1  current op is a store.
- regWrtEn  in  1  current op writes a register.
- memSel  in  2  target select: 0 = data RAM, 1-3 = I/O devices.
- destReg  in  4  writeback register index.
- aluOut  in  32  ALU result; this is the address for loads and stores and the writeback data for ALU ops.
- dataIn  in  32  store data.
- stall  out  1  hold the upstream pipeline register (combinational).
- busReq  out  1  transaction request (registered).
- busWr  out  1  1 = write, 0 = read; valid while busReq is high.
- busSel  out  2  latched memSel.
- busAddr  out  32  latched address.
- busWrData  out  32  latched store data.
- busAck  in  1  responder completion; sampled only while busReq is high.
- busRdData  in  32  read data; valid in the busAck cycle.
- wbEn  out  1  writeback strobe (registered, one cycle per op).
- wbReg  out  4  writeback register index.
- wbData  out  32  writeback value.
- busErr  out  1  one-cycle pulse on timeout.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE, isLoad|isStore high:**
  - Latch aluOut, dataIn, memSel, destReg and regWrtEn.
  - Set busWr = isStore & ~isLoad.
  - Go to BUSY.
- **IDLE, no memory op:** next cycle wbEn = regWrtEn, wbReg = destReg, wbData = aluOut. Stay in IDLE.
- **isLoad and isStore both high:** treated as a load.
- **BUSY:**
  - busReq = 1, with busAddr/busWr/busSel/busWrData held stable.
  - waitCnt increments each cycle that busAck is low.
  - busAck high: go to DONE. For a load, next cycle wbEn = latched regWrtEn, wbReg = latched destReg, wbData = busRdData.
  - busAck low and waitCnt == TIMEOUT-1: go to DONE, busErr = 1 next cycle, wbEn = 0.
  - busAck high on the timeout cycle: the acknowledge wins and busErr stays 0.
- **DONE:**
  - busReq = 0.
  - Inputs are ignored, because they still show the just-completed op.
  - Unconditionally go to IDLE.
- **stall** = (IDLE & (isLoad|isStore)) | BUSY. stall is low in DONE, so the upstream register advances exactly once.
- **Store behaviour:** a store never asserts wbEn. busRdData is ignored for stores.
- **busAck outside BUSY:** ignored.
- **Reset (rst low, any time, including mid-transaction):** immediately forces:
  - state = IDLE, waitCnt = 0
  - busReq = 0, busWr = 0, busSel = 0, busAddr = 0, busWrData = 0
  - wbEn = 0, wbReg = 0, wbData = 0, busErr = 0

  No pending operation survives reset. stall then follows its combinational definition.

## Timing
- Memory op first visible in cycle 0 (IDLE): stall is high in cycle 0.
- busReq rises in cycle 1.
- busAck first seen high in cycle k: busReq falls in cycle k+1 (DONE), and wbEn pulses in cycle k+1 for a load.
- stall is high in cycles 0..k and low in k+1. The next instruction is visible in cycle k+2.
- Zero-wait responder (ack in cycle 1): a load occupies 3 cycles.
- Timeout: busReq is high for exactly TIMEOUT cycles (1..TIMEOUT). busErr pulses in cycle TIMEOUT+1.
- Non-memory op: wbEn is valid one cycle after the op is presented. No stall.
- Back-to-back ALU ops give a wbEn pulse every cycle.

## Test plan
- **Reset:** assert rst low mid-BUSY at an arbitrary time -> all outputs 0 in the same cycle; after release the unit sits in IDLE with stall = 0.
- **ALU op:** regWrtEn = 1, destReg = 4'h3, aluOut = 32'h0000_00A5 -> next cycle wbEn = 1, wbReg = 3, wbData = 32'hA5; stall never high.
- **Load, 2 wait states:**
  - Stimulus: isLoad, aluOut = 32'h0000_0100, memSel = 0; responder acks in cycle 3 with busRdData = 32'hCAFE_F00D.
  - Required: busReq high in cycles 1-3, busWr = 0, busAddr = 32'h100; stall high in cycles 0-3; wbData = 32'hCAFEF00D with wbEn in cycle 4.
- **Store to I/O:**
  - Stimulus: isStore, memSel = 2, aluOut = 32'hF000_0000, dataIn = 32'h1234_5678; ack in cycle 1.
  - Required: busWr = 1, busSel = 2, busWrData = 32'h12345678; wbEn stays 0; stall low in cycle 2.
- **Timeout:** TIMEOUT = 4, load, busAck never asserted -> busReq high in cycles 1-4; busErr = 1 in cycle 5 only; wbEn = 0; unit returns to IDLE in cycle 6.
- **Ack at the limit plus stray acks:**
  - Stimulus: TIMEOUT = 4 with ack in cycle 4; separately, busAck pulsed while in IDLE.
  - Required: the load completes normally with busErr = 0; the stray ack produces no busReq, wbEn or state change.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: runs loads/stores as req/ack bus transactions,
// stalls the pipeline while busy and drives the registered writeback port.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic        regWrtEn,
  input  logic [1:0]  memSel,
  input  logic [3:0]  destReg,
  input  logic [31:0] aluOut,
  input  logic [31:0] dataIn,
  output logic        stall,
  output logic        busReq,
  output logic        busWr,
  output logic [1:0]  busSel,
  output logic [31:0] busAddr,
  output logic [31:0] busWrData,
  input  logic        busAck,
  input  logic [31:0] busRdData,
  output logic        wbEn,
  output logic [3:0]  wbReg,
  output logic [31:0] wbData,
  output logic        busErr
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  waitCnt;
  logic        latWen;
  logic [3:0]  latReg;

  assign stall = ((state == IDLE) && (isLoad || isStore)) || (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      latWen    <= 1'b0;
      latReg    <= '0;
      busReq    <= 1'b0;
      busWr     <= 1'b0;
      busSel    <= '0;
      busAddr   <= '0;
      busWrData <= '0;
      wbEn      <= 1'b0;
      wbReg     <= '0;
      wbData    <= '0;
      busErr    <= 1'b0;
    end else begin
      wbEn   <= 1'b0;
      busErr <= 1'b0;
      case (state)
        IDLE: begin
          if (isLoad || isStore) begin
            busAddr   <= aluOut;
            busWrData <= dataIn;
            busSel    <= memSel;
            latReg    <= destReg;
            latWen    <= regWrtEn;
            busWr     <= isStore & ~isLoad;
            busReq    <= 1'b1;
            waitCnt   <= '0;
            state     <= BUSY;
          end else begin
            wbEn   <= regWrtEn;
            wbReg  <= destReg;
            wbData <= aluOut;
          end
        end
        BUSY: begin
          // An acknowledge on the final wait cycle still completes the access.
          if (busAck) begin
            busReq <= 1'b0;
            state  <= DONE;
            if (!busWr) begin
              wbEn   <= latWen;
              wbReg  <= latReg;
              wbData <= busRdData;
            end
          end else if (waitCnt == LIMIT) begin
            busReq <= 1'b0;
            busErr <= 1'b1;
            state  <= DONE;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
